// File: rtl/display_pkg.sv
// Shared definitions for the display feed path: default widths, FIFO
// occupancy states and a pointer-width helper.
package display_pkg;

   localparam int unsigned DISP_DATA_W     = 16;
   localparam int unsigned DISP_FIFO_DEPTH = 16;

   // EMPTY  : nothing buffered, output register idle
   // PRIMED : output register holds a word, RAM empty
   // FILLING: RAM holds at least one word, total below capacity
   // FULL   : total occupancy equals DEPTH
   typedef enum logic [1:0] {
      EMPTY,
      PRIMED,
      FILLING,
      FULL
   } fifo_state_e;

   // Address width for an n-entry array; never narrower than one bit.
   function automatic int unsigned ptr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/display_feed_ram.sv
// Simple dual-port RAM backing the display feed FIFO: synchronous write,
// registered read. A read of the address being written in the same cycle
// returns the new word, so the FIFO head is always current one cycle later.
module display_feed_ram
   import display_pkg::*;
#(
   parameter int unsigned DATA_W = DISP_DATA_W,
   parameter int unsigned DEPTH  = DISP_FIFO_DEPTH - 1
) (
   input  logic                          clk_hifreq,
   input  logic                          we,
   input  logic [ptr_width(DEPTH)-1:0]   wr_addr,
   input  logic [DATA_W-1:0]             wr_data,
   input  logic [ptr_width(DEPTH)-1:0]   rd_addr,
   output logic [DATA_W-1:0]             rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage write port.
   always_ff @(posedge clk_hifreq) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered read with write-through on an address collision.
   always_ff @(posedge clk_hifreq) begin
      if (we && (wr_addr == rd_addr)) begin
         rd_data <= wr_data;
      end else begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/display_feed_fifo.sv
// Buffer between the tick/price producer and the display block. Words are
// held in a (DEPTH-1)-entry circular RAM plus one output register, released
// one per out_ready pulse. Writes arriving while full are either dropped and
// counted (DROP_ON_FULL=1) or backpressured through in_ready.
module display_feed_fifo
   import display_pkg::*;
#(
   parameter int unsigned DATA_W       = DISP_DATA_W,
   parameter int unsigned DEPTH        = DISP_FIFO_DEPTH,
   parameter bit          DROP_ON_FULL = 1'b1,
   parameter int unsigned CNT_W        = 8
) (
   input  logic                      clk_hifreq,
   input  logic                      rst,
   input  logic                      flush,
   input  logic [DATA_W-1:0]         in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      full,
   output logic [CNT_W-1:0]          drop_cnt
);

   localparam int unsigned RAM_DEPTH = DEPTH - 1;
   localparam int unsigned ADDR_W    = ptr_width(RAM_DEPTH);
   localparam int unsigned LVL_W     = $clog2(DEPTH) + 1;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);
   localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);
   localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);

   fifo_state_e        state_q, state_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [DATA_W-1:0]  out_data_q, out_data_d;
   logic [CNT_W-1:0]   drop_cnt_q;
   logic [DATA_W-1:0]  ram_head;
   logic               ram_we;
   logic               ram_empty;
   logic               accept;
   logic               pop;
   logic               drop;

   // Circular increment modulo RAM_DEPTH.
   function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
      return (p == LAST_ADDR) ? '0 : p + ADDR_W'(1);
   endfunction

   assign full      = (state_q == FULL);
   assign out_valid = (state_q != EMPTY);
   assign ram_empty = (state_q == EMPTY) || (state_q == PRIMED);
   assign in_ready  = DROP_ON_FULL ? 1'b1 : !full;

   // full is registered, so a pop in the same cycle never opens a slot early.
   assign accept = in_valid && !full;
   assign pop    = out_valid && out_ready;
   assign drop   = DROP_ON_FULL && in_valid && full && !flush;

   assign out_data = out_data_q;
   assign level    = level_q;
   assign drop_cnt = drop_cnt_q;

   // The RAM is addressed with the next head pointer so that ram_head always
   // reflects the current head word; this lets a pop reload the output
   // register on the same edge despite the registered read.
   display_feed_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (RAM_DEPTH)
   ) u_ram (
      .clk_hifreq (clk_hifreq),
      .we         (ram_we),
      .wr_addr    (wr_ptr_q),
      .wr_data    (in_data),
      .rd_addr    (rd_ptr_d),
      .rd_data    (ram_head)
   );

   // Next-state: routes accepted words to the output register or RAM,
   // advances pointers, tracks occupancy and derives the occupancy state.
   always_comb begin
      level_d    = level_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      out_data_d = out_data_q;
      ram_we     = 1'b0;

      if (flush) begin
         level_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         if (pop) begin
            if (!ram_empty) begin
               out_data_d = ram_head;
               rd_ptr_d   = ptr_inc(rd_ptr_q);
            end else if (accept) begin
               out_data_d = in_data;
            end
         end else if (!out_valid && accept) begin
            out_data_d = in_data;
         end

         // A word bypasses the RAM only when the output register is free
         // after this edge and the RAM has nothing older.
         if (accept && out_valid && !(pop && ram_empty)) begin
            ram_we   = 1'b1;
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end

         case ({accept, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
         endcase
      end

      if (level_d == '0) begin
         state_d = EMPTY;
      end else if (level_d == LVL_ONE) begin
         state_d = PRIMED;
      end else if (level_d == LVL_FULL) begin
         state_d = FULL;
      end else begin
         state_d = FILLING;
      end
   end

   // State, occupancy, pointers and output register.
   always_ff @(posedge clk_hifreq or negedge rst) begin
      if (!rst) begin
         state_q    <= EMPTY;
         level_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         level_q    <= level_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         out_data_q <= out_data_d;
      end
   end

   // Saturating count of words discarded while full; flush leaves it alone.
   always_ff @(posedge clk_hifreq or negedge rst) begin
      if (!rst) begin
         drop_cnt_q <= '0;
      end else if (drop && (drop_cnt_q != '1)) begin
         drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      end
   end

endmodule
